// File: rtl/vdp_super_vram_arbiter.sv
// Slot-based arbiter sharing one 32-bit VRAM port between refresh, super-res display fetch,
// CPU and command engine; read data is routed back through an owner-tag latency pipeline.
module vdp_super_vram_arbiter #(
    parameter int unsigned READ_LATENCY = 4,
    parameter int unsigned REFRESH_CX   = 723
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vdp_super,
    input  logic [10:0] cx,
    input  logic        super_res_drawing,
    input  logic [16:0] disp_addr,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [16:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_be,
    output logic        cpu_ack,
    output logic        cpu_rd_valid,
    output logic [31:0] cpu_rdata,
    input  logic        cmd_req,
    input  logic        cmd_we,
    input  logic [16:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_be,
    output logic        cmd_ack,
    output logic        cmd_rd_valid,
    output logic [31:0] cmd_rdata,
    output logic        disp_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_refresh,
    output logic [16:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {TagNone, TagCpu, TagCmd} tag_t;

    // Only the slot index matters: a misaligned REFRESH_CX fires at its slot start.
    localparam logic [8:0] RefreshSlot = 9'(REFRESH_CX >> 2);

    logic        slot_start;
    logic        refresh_win, disp_win, cpu_win, cmd_win;
    logic        last_cmd_q, last_cmd_d;
    tag_t        new_tag, ret_tag;
    tag_t        tag_q [READ_LATENCY];

    logic [16:0] mem_addr_d;
    logic [31:0] mem_wdata_d;
    logic [3:0]  mem_be_d;
    logic        mem_we_d;

    assign slot_start = (cx[1:0] == 2'b00);
    assign ret_tag    = tag_q[READ_LATENCY-1];

    always_comb begin
        refresh_win = 1'b0;
        disp_win    = 1'b0;
        cpu_win     = 1'b0;
        cmd_win     = 1'b0;
        if (slot_start) begin
            if (cx[10:2] == RefreshSlot) begin
                refresh_win = 1'b1;
            end else if (vdp_super && super_res_drawing) begin
                disp_win = 1'b1;
            end else if (cpu_req && (!cmd_req || last_cmd_q)) begin
                cpu_win = 1'b1;
            end else if (cmd_req) begin
                cmd_win = 1'b1;
            end
        end
    end

    always_comb begin
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_be_d    = mem_be;
        mem_we_d    = mem_we;
        last_cmd_d  = last_cmd_q;
        new_tag     = TagNone;
        if (refresh_win) begin
            mem_addr_d  = '0;
            mem_wdata_d = '0;
            mem_be_d    = '0;
            mem_we_d    = 1'b0;
        end else if (disp_win) begin
            mem_addr_d  = disp_addr;
            mem_wdata_d = '0;
            mem_be_d    = 4'hF;
            mem_we_d    = 1'b0;
        end else if (cpu_win) begin
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            mem_be_d    = cpu_be;
            mem_we_d    = cpu_we;
            last_cmd_d  = 1'b0;
            new_tag     = cpu_we ? TagNone : TagCpu;
        end else if (cmd_win) begin
            mem_addr_d  = cmd_addr;
            mem_wdata_d = cmd_wdata;
            mem_be_d    = cmd_be;
            mem_we_d    = cmd_we;
            last_cmd_d  = 1'b1;
            new_tag     = cmd_we ? TagNone : TagCmd;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // last_cmd_q=1 means the CPU wins the next tie.
            last_cmd_q   <= 1'b1;
            cpu_ack      <= 1'b0;
            cmd_ack      <= 1'b0;
            disp_ack     <= 1'b0;
            mem_req      <= 1'b0;
            mem_refresh  <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
            cpu_rd_valid <= 1'b0;
            cmd_rd_valid <= 1'b0;
            cpu_rdata    <= '0;
            cmd_rdata    <= '0;
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                tag_q[i] <= TagNone;
            end
        end else begin
            last_cmd_q  <= last_cmd_d;
            cpu_ack     <= cpu_win;
            cmd_ack     <= cmd_win;
            disp_ack    <= disp_win;
            mem_req     <= disp_win | cpu_win | cmd_win;
            mem_refresh <= refresh_win;
            mem_we      <= mem_we_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
            mem_be      <= mem_be_d;
            tag_q[0]    <= new_tag;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            cpu_rd_valid <= (ret_tag == TagCpu);
            cmd_rd_valid <= (ret_tag == TagCmd);
            if (ret_tag == TagCpu) cpu_rdata <= mem_rdata;
            if (ret_tag == TagCmd) cmd_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_vdp_super_vram_arbiter.sv
// Scoreboard bench: directed slots push expected grants/reads; a negedge monitor pops and checks.
module tb_vdp_super_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vdp_super;
    logic [10:0] cx;
    logic        super_res_drawing;
    logic [16:0] disp_addr;
    logic        cpu_req, cpu_we;
    logic [16:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_be;
    logic        cpu_ack, cpu_rd_valid;
    logic [31:0] cpu_rdata;
    logic        cmd_req, cmd_we;
    logic [16:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_be;
    logic        cmd_ack, cmd_rd_valid;
    logic [31:0] cmd_rdata;
    logic        disp_ack, mem_req, mem_we, mem_refresh;
    logic [16:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    logic rd_mode = 1'b0;

    // kind: 0 display, 1 cpu, 2 cmd, 3 refresh
    typedef struct {
        int          kind;
        int          cxv;
        logic [16:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } grant_t;

    typedef struct {
        int          kind;
        int          cxv;
        logic [31:0] data;
    } read_t;

    grant_t gq[$];
    read_t  rq[$];

    vdp_super_vram_arbiter #(.READ_LATENCY(4), .REFRESH_CX(723)) dut (
        .clk(clk), .reset_n(reset_n), .vdp_super(vdp_super), .cx(cx),
        .super_res_drawing(super_res_drawing), .disp_addr(disp_addr),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_be(cpu_be), .cpu_ack(cpu_ack), .cpu_rd_valid(cpu_rd_valid), .cpu_rdata(cpu_rdata),
        .cmd_req(cmd_req), .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_be(cmd_be), .cmd_ack(cmd_ack), .cmd_rd_valid(cmd_rd_valid), .cmd_rdata(cmd_rdata),
        .disp_ack(disp_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_refresh(mem_refresh),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory data pattern tagged with the cx of the cycle it is presented in.
    function automatic logic [31:0] fdat(input int v);
        fdat = {5'h0, 11'(v), 16'hCAFE};
    endfunction

    task automatic set_cx(input int v);
        cx = 11'(v);
        mem_rdata = rd_mode ? fdat(v) : 32'hDEADBEEF;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            set_cx(int'(cx) + 1);
        end
    endtask

    task automatic set_cpu(input logic r, input logic w, input logic [16:0] a,
                           input logic [31:0] d, input logic [3:0] b);
        cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d; cpu_be = b;
    endtask

    task automatic set_cmd(input logic r, input logic w, input logic [16:0] a,
                           input logic [31:0] d, input logic [3:0] b);
        cmd_req = r; cmd_we = w; cmd_addr = a; cmd_wdata = d; cmd_be = b;
    endtask

    task automatic exp_grant(input int k, input int c, input logic [16:0] a, input logic w,
                             input logic [31:0] d, input logic [3:0] b);
        grant_t g;
        g.kind = k; g.cxv = c; g.addr = a; g.we = w; g.wdata = d; g.be = b;
        gq.push_back(g);
    endtask

    task automatic exp_read(input int k, input int c, input logic [31:0] d);
        read_t r;
        r.kind = k; r.cxv = c; r.data = d;
        rq.push_back(r);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " cpu_ack"}, 32'(cpu_ack), 32'h0);
        chk({tag, " cpu_rd_valid"}, 32'(cpu_rd_valid), 32'h0);
        chk({tag, " cpu_rdata"}, cpu_rdata, 32'h0);
        chk({tag, " cmd_ack"}, 32'(cmd_ack), 32'h0);
        chk({tag, " cmd_rd_valid"}, 32'(cmd_rd_valid), 32'h0);
        chk({tag, " cmd_rdata"}, cmd_rdata, 32'h0);
        chk({tag, " disp_ack"}, 32'(disp_ack), 32'h0);
        chk({tag, " mem_req"}, 32'(mem_req), 32'h0);
        chk({tag, " mem_we"}, 32'(mem_we), 32'h0);
        chk({tag, " mem_refresh"}, 32'(mem_refresh), 32'h0);
        chk({tag, " mem_addr"}, 32'(mem_addr), 32'h0);
        chk({tag, " mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, " mem_be"}, 32'(mem_be), 32'h0);
    endtask

    // Grant monitor
    always @(negedge clk) begin
        if (mon_en && (mem_req || mem_refresh || cpu_ack || cmd_ack || disp_ack)) begin
            int gk;
            logic ok;
            grant_t g;
            if (!mem_refresh && mem_req && disp_ack && !cpu_ack && !cmd_ack) gk = 0;
            else if (!mem_refresh && mem_req && cpu_ack && !disp_ack && !cmd_ack) gk = 1;
            else if (!mem_refresh && mem_req && cmd_ack && !disp_ack && !cpu_ack) gk = 2;
            else if (mem_refresh && !mem_req && !cpu_ack && !cmd_ack && !disp_ack) gk = 3;
            else gk = 7;
            checks++;
            if (gq.size() == 0) begin
                errors++;
                $display("FAIL grant_unexpected: kind %0d at cx %0d, none expected", gk, cx);
            end else begin
                g = gq.pop_front();
                ok = (gk == g.kind) && (int'(cx) == g.cxv);
                if (g.kind == 0) ok = ok && (mem_addr == g.addr) && !mem_we && (mem_be == 4'hF);
                if (g.kind == 1 || g.kind == 2)
                    ok = ok && (mem_addr == g.addr) && (mem_we == g.we) &&
                         (mem_wdata == g.wdata) && (mem_be == g.be);
                if (!ok) begin
                    errors++;
                    $display("FAIL grant: got kind %0d cx %0d addr %h we %b wdata %h be %h; expected kind %0d cx %0d addr %h we %b wdata %h be %h",
                             gk, cx, mem_addr, mem_we, mem_wdata, mem_be,
                             g.kind, g.cxv, g.addr, g.we, g.wdata, g.be);
                end
            end
        end
    end

    // Read-return monitor
    always @(negedge clk) begin
        if (mon_en && (cpu_rd_valid || cmd_rd_valid)) begin
            int rk;
            logic [31:0] rd;
            read_t r;
            rk = (cpu_rd_valid && !cmd_rd_valid) ? 1 : (cmd_rd_valid && !cpu_rd_valid) ? 2 : 7;
            rd = (rk == 2) ? cmd_rdata : cpu_rdata;
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL read_unexpected: owner %0d data %h at cx %0d, none expected",
                         rk, rd, cx);
            end else begin
                r = rq.pop_front();
                if (rk != r.kind || int'(cx) != r.cxv || rd !== r.data) begin
                    errors++;
                    $display("FAIL read: got owner %0d cx %0d data %h; expected owner %0d cx %0d data %h",
                             rk, cx, rd, r.kind, r.cxv, r.data);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0; vdp_super = 1'b0; super_res_drawing = 1'b0; disp_addr = '0;
        set_cpu(1'b0, 1'b0, '0, '0, '0);
        set_cmd(1'b0, 1'b0, '0, '0, '0);
        set_cx(0);
        step(3);
        @(negedge clk);
        check_zero("reset");
        step(1);
        reset_n = 1'b1;
        mon_en = 1'b1;
        step(2);

        // Contention, CPU-first after reset: CPU, CMD, CPU, CMD
        rd_mode = 1'b1;
        set_cx(100);
        set_cpu(1'b1, 1'b1, 17'h00AAA, 32'h11111111, 4'hF);
        set_cmd(1'b1, 1'b0, 17'h00BBB, 32'h22222222, 4'hF);
        exp_grant(1, 101, 17'h00AAA, 1'b1, 32'h11111111, 4'hF);
        exp_grant(2, 105, 17'h00BBB, 1'b0, 32'h22222222, 4'hF);
        exp_read(2, 109, fdat(108));
        exp_grant(1, 109, 17'h00AAA, 1'b1, 32'h11111111, 4'hF);
        exp_grant(2, 113, 17'h00BBB, 1'b0, 32'h22222222, 4'hF);
        exp_read(2, 117, fdat(116));
        step(16);
        cpu_req = 1'b0; cmd_req = 1'b0;
        step(8);

        // CPU-only read with constant memory data
        rd_mode = 1'b0;
        set_cx(200);
        set_cpu(1'b1, 1'b0, 17'h00123, 32'h0, 4'hF);
        exp_grant(1, 201, 17'h00123, 1'b0, 32'h0, 4'hF);
        exp_read(1, 205, 32'hDEADBEEF);
        step(4);
        cpu_req = 1'b0;
        step(8);

        // Display priority over a waiting CPU, then CPU once drawing ends
        rd_mode = 1'b1;
        set_cx(300);
        vdp_super = 1'b1; super_res_drawing = 1'b1; disp_addr = 17'h00010;
        set_cpu(1'b1, 1'b0, 17'h00124, 32'h0, 4'hF);
        exp_grant(0, 301, 17'h00010, 1'b0, 32'h0, 4'hF);
        exp_grant(0, 305, 17'h00010, 1'b0, 32'h0, 4'hF);
        exp_grant(0, 309, 17'h00010, 1'b0, 32'h0, 4'hF);
        exp_grant(1, 313, 17'h00124, 1'b0, 32'h0, 4'hF);
        exp_read(1, 317, fdat(316));
        step(12);
        super_res_drawing = 1'b0;
        step(4);
        cpu_req = 1'b0;
        step(8);

        // vdp_super=0: drawing ignored, command served
        vdp_super = 1'b0; super_res_drawing = 1'b1;
        set_cx(400);
        set_cmd(1'b1, 1'b0, 17'h00456, 32'h0, 4'hF);
        exp_grant(2, 401, 17'h00456, 1'b0, 32'h0, 4'hF);
        exp_read(2, 405, fdat(404));
        step(4);
        cmd_req = 1'b0; super_res_drawing = 1'b0;
        step(8);

        // Refresh slot 720 preempts a pending CPU write
        set_cx(716);
        set_cpu(1'b1, 1'b1, 17'h00300, 32'h33333333, 4'h3);
        exp_grant(1, 717, 17'h00300, 1'b1, 32'h33333333, 4'h3);
        exp_grant(3, 721, 17'h0, 1'b0, 32'h0, 4'h0);
        exp_grant(1, 725, 17'h00300, 1'b1, 32'h33333333, 4'h3);
        step(12);
        cpu_req = 1'b0;
        step(4);

        // Command byte write at top address: no read return
        set_cx(800);
        set_cmd(1'b1, 1'b1, 17'h1FFFF, 32'h00AB0000, 4'b0100);
        exp_grant(2, 801, 17'h1FFFF, 1'b1, 32'h00AB0000, 4'b0100);
        step(4);
        cmd_req = 1'b0;
        step(8);

        // Reset two clocks after a CPU read issues: the read is dropped
        set_cx(900);
        set_cpu(1'b1, 1'b0, 17'h00055, 32'h0, 4'hF);
        exp_grant(1, 901, 17'h00055, 1'b0, 32'h0, 4'hF);
        step(1);
        cpu_req = 1'b0;
        step(2);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        @(negedge clk);
        check_zero("midreset");
        step(4);

        // Dual request after reset goes to the CPU
        set_cx(920);
        set_cpu(1'b1, 1'b0, 17'h00066, 32'h0, 4'hF);
        set_cmd(1'b1, 1'b0, 17'h00077, 32'h0, 4'hF);
        exp_grant(1, 921, 17'h00066, 1'b0, 32'h0, 4'hF);
        exp_read(1, 925, fdat(924));
        step(4);
        cpu_req = 1'b0; cmd_req = 1'b0;
        step(12);

        @(negedge clk);
        chk("cpu_rdata_hold", cpu_rdata, fdat(924));
        chk("grant_queue_empty", 32'(gq.size()), 32'h0);
        chk("read_queue_empty", 32'(rq.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vdp_super_vram_arbiter.md
Name: vdp_super_vram_arbiter

Overview:
- Shares the single 32-bit VRAM port between four users: super-res display fetch, CPU port, command engine and SDRAM refresh.
- Access is divided into fixed 4-clock slots aligned to cx[1:0]. Each slot is granted to at most one owner.
- Read data is routed back to the owner through a latency-tracking pipeline.
- Sits between the super-res pixel pipeline, the CPU/command front-ends and the VRAM controller.

Parameters:
- READ_LATENCY, 4, clocks from the mem_req pulse to valid mem_rdata (1..7).
- REFRESH_CX, 723, cx value whose slot is reserved for refresh on every line.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- vdp_super  in  1  super-res mode enable
- cx  in  11  horizontal pixel counter
- super_res_drawing  in  1  display fetch window active
- disp_addr  in  17  display fetch word address
- cpu_req  in  1  CPU access request (level)
- cpu_we  in  1  CPU write
- cpu_addr  in  17  CPU word address
- cpu_wdata  in  32  CPU write data
- cpu_be  in  4  CPU byte enables
- cpu_ack  out  1  CPU grant pulse
- cpu_rd_valid  out  1  CPU read data valid pulse
- cpu_rdata  out  32  CPU read data
- cmd_req, cmd_we, cmd_addr, cmd_wdata, cmd_be  in  1/1/17/32/4  command engine request, same meaning as cpu_*
- cmd_ack, cmd_rd_valid, cmd_rdata  out  1/1/32  command engine grant, read valid, read data
- disp_ack  out  1  display fetch issued this slot
- mem_req  out  1  VRAM access strobe
- mem_we  out  1  VRAM write
- mem_refresh  out  1  VRAM refresh strobe
- mem_addr  out  17  VRAM word address
- mem_wdata  out  32  VRAM write data
- mem_be  out  4  VRAM byte enables
- mem_rdata  in  32  VRAM read data

Behaviour:
- Reset (reset_n=0 sampled at a clk edge):
  - All outputs 0; round-robin pointer set to CPU-first.
  - In-flight read tracking cleared, so no rd_valid is issued for reads already in flight.
  - Reset mid-slot aborts the slot.
- Arbitration:
  - Evaluated only on clocks where cx[1:0]==0.
  - Requests and addresses sampled on that clock; a req rising on that same clock is eligible.
- Priority, highest first:
  1. Refresh, when cx==REFRESH_CX. REFRESH_CX must be ≡0 mod 4 in integration; if it is not, refresh fires at the slot start containing it, i.e. cx=={REFRESH_CX[10:2],2'b00}.
  2. Display, when vdp_super & super_res_drawing.
  3. CPU vs command, by round-robin:
     - If both request, grant the one not granted last; pointer updates only on a CPU/command grant.
     - A single requester always wins.
  4. No requester: idle slot, mem_req stays 0.
- Issue cycle (cx[1:0]==1, i.e. one clock after arbitration):
  - Exactly one of these strobes for the granted owner: mem_req (display/CPU/command) or mem_refresh (refresh).
  - mem_addr, mem_we, mem_wdata and mem_be are registered from the winner and held until the next issue.
  - Display: mem_we=0, mem_be=4'hF.
  - The matching ack (disp_ack, cpu_ack or cmd_ack) pulses high for exactly this clock.
- Requester handshake:
  - Keeps req, addr, we, wdata and be stable until it sees ack.
  - Req still high on the clock after ack is treated as a new request.
  - A request dropped before ack is simply not served; no error.
- Read return:
  - Owner tag {cpu, cmd, none} shifts through a READ_LATENCY-deep pipeline.
  - Exactly READ_LATENCY clocks after a read mem_req, mem_rdata is captured into the owner's rdata register and the owner's rd_valid pulses for 1 clock.
  - Writes, refresh and display produce no rd_valid; display consumes mem_rdata directly.
  - cpu_rdata and cmd_rdata hold their value between pulses.
- Mode and timing:
  - vdp_super=0: display is never granted; refresh and CPU/command still arbitrate.
  - super_res_drawing falling mid-slot does not cancel an already-granted display access.
  - cx wrap (end of line back to 0) needs no special handling; slots follow cx[1:0] only.
- Throughput: at most one access per 4 clocks; read tracking must support back-to-back reads in consecutive slots with no loss.

Test Plan:
- CPU-only read: cpu_req=1, cpu_addr=17'h00123, mem_rdata=32'hDEADBEEF, drawing=0 -> cpu_ack at cx%4==1; mem_addr=0x00123, mem_we=0; cpu_rd_valid 4 clocks later; cpu_rdata=32'hDEADBEEF.
- Contention: cpu_req and cmd_req held high for 4 slots, drawing=0 -> grants CPU, CMD, CPU, CMD; each ack exactly 1 clock.
- Display priority: super_res_drawing=1, vdp_super=1, disp_addr=17'h00010, cpu_req=1 -> disp_ack in each slot, cpu_ack never; drop drawing -> CPU granted on the next slot.
- Refresh: cx reaches 723 (slot start 720) with cpu_req=1 -> mem_refresh=1 and mem_req=0 in that slot; CPU served in the following slot.
- Byte write: cmd_we=1, cmd_be=4'b0100, cmd_wdata=32'h00AB0000, cmd_addr=17'h1FFFF -> mem_we=1, mem_be=4'b0100, mem_addr=17'h1FFFF; no cmd_rd_valid.
- Reset mid-read: CPU read issued, reset_n=0 for 1 clock 2 clocks later -> no cpu_rd_valid; all outputs 0; pointer CPU-first on the next dual request.
